hazard_detector: RTL and testbench

Produces the four hazard inputs of the pipeline stage controller: load-use data hazard, branch hazard, delayed branch hazard and branch miss. Watches decode-stage operand usage, the execute-stage destination and the branch resolution bus. Tracks the single outstanding branch with a small FSM and emits a registered one-cycle miss pulse with the redirect PC. Sits between decode/execute and the stage controller. Also supplies the miss performance counter and a resolution watchdog flag.

---
 rtl/hazard_detector_if.sv | 48 ++++
 rtl/hazard_detector.sv | 110 +++++++++++
 tb/tb_hazard_detector.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_detector_if.sv
// Signal bundle between decode/execute/branch-resolution and the hazard detector.
// The pipeline side is the master and drives operand/resolve info; the detector is the slave and returns hazard flags.
interface hazard_detector_if #(
   parameter int REG_ADDR_WIDTH = 5,
   parameter int ADDR_WIDTH     = 32
);
   logic                      dValid;
   logic                      dIsBranch;
   logic                      dRs1Used;
   logic                      dRs2Used;
   logic [REG_ADDR_WIDTH-1:0] dRs1Addr;
   logic [REG_ADDR_WIDTH-1:0] dRs2Addr;
   logic                      eValid;
   logic                      eIsLoad;
   logic                      eRdWrite;
   logic [REG_ADDR_WIDTH-1:0] eRdAddr;
   logic                      resolveValid;
   logic                      resolveTaken;
   logic                      resolvePredTaken;
   logic [ADDR_WIDTH-1:0]     resolveTarget;
   logic [ADDR_WIDTH-1:0]     resolvePredTarget;
   logic [ADDR_WIDTH-1:0]     resolvePc;
   logic                      isDataHazard;
   logic                      isBranchHazard;
   logic                      isBranchHazardDelayed;
   logic                      isMiss;
   logic [ADDR_WIDTH-1:0]     redirectPc;
   logic [31:0]               missCount;
   logic                      watchdogTrip;

   modport master (
      output dValid, dIsBranch, dRs1Used, dRs2Used, dRs1Addr, dRs2Addr,
             eValid, eIsLoad, eRdWrite, eRdAddr,
             resolveValid, resolveTaken, resolvePredTaken,
             resolveTarget, resolvePredTarget, resolvePc,
      input  isDataHazard, isBranchHazard, isBranchHazardDelayed,
             isMiss, redirectPc, missCount, watchdogTrip
   );

   modport slave (
      input  dValid, dIsBranch, dRs1Used, dRs2Used, dRs1Addr, dRs2Addr,
             eValid, eIsLoad, eRdWrite, eRdAddr,
             resolveValid, resolveTaken, resolvePredTaken,
             resolveTarget, resolvePredTarget, resolvePc,
      output isDataHazard, isBranchHazard, isBranchHazardDelayed,
             isMiss, redirectPc, missCount, watchdogTrip
   );
endinterface

// File: rtl/hazard_detector.sv
// Load-use and branch hazard detection for the stage controller, tracking the single outstanding
// branch and producing a registered misprediction pulse with the redirect PC.
module hazard_detector #(
   parameter int REG_ADDR_WIDTH = 5,
   parameter int ADDR_WIDTH     = 32,
   parameter int WATCHDOG_LIMIT = 15
) (
   input logic               clk,
   input logic               rst,
   hazard_detector_if.slave  bus
);
   localparam int WDW = $clog2(WATCHDOG_LIMIT + 1);
   localparam logic [WDW-1:0] WD_MAX = WDW'(WATCHDOG_LIMIT);
   localparam logic [WDW-1:0] WD_ONE = WDW'(1);

   localparam logic [0:0] IDLE    = 1'b0;
   localparam logic [0:0] PENDING = 1'b1;

   logic [0:0]            state;
   logic [WDW-1:0]        wdCount;
   logic                  tripReg;
   logic                  missReg;
   logic                  delayedReg;
   logic [ADDR_WIDTH-1:0] redirectReg;
   logic [31:0]           missCountReg;
   logic                  dataHazard;
   logic                  branchHazard;
   logic                  mispredict;

   // Register 0 is hardwired, so a load targeting it can never create a dependency.
   always_comb begin
      dataHazard = bus.dValid & bus.eValid & bus.eIsLoad & bus.eRdWrite
                 & (bus.eRdAddr != REG_ADDR_WIDTH'(0))
                 & ((bus.dRs1Used & (bus.dRs1Addr == bus.eRdAddr))
                  | (bus.dRs2Used & (bus.dRs2Addr == bus.eRdAddr)));
   end

   // A branch held back by a load-use stall, or flushed by a miss, must not count as in flight yet.
   always_comb begin
      branchHazard = 1'b1;
      if (state == IDLE)
         branchHazard = bus.dValid & bus.dIsBranch & ~dataHazard & ~missReg;
   end

   always_comb begin
      mispredict = bus.resolveValid
                 & ((bus.resolveTaken != bus.resolvePredTaken)
                  | (bus.resolveTaken & (bus.resolveTarget != bus.resolvePredTarget)));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         wdCount <= '0;
         tripReg <= 1'b0;
      end else if (missReg) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (branchHazard) begin
                  state   <= PENDING;
                  wdCount <= '0;
               end
            end
            PENDING: begin
               if (bus.resolveValid) begin
                  state <= IDLE;
               end else if (wdCount != WD_MAX) begin
                  wdCount <= wdCount + WD_ONE;
                  if ((wdCount + WD_ONE) == WD_MAX)
                     tripReg <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // The redirect PC is only updated on a miss so that it holds across correct predictions.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         missReg      <= 1'b0;
         redirectReg  <= '0;
         missCountReg <= '0;
      end else begin
         missReg <= mispredict;
         if (mispredict) begin
            redirectReg  <= bus.resolveTaken ? bus.resolveTarget
                                             : bus.resolvePc + ADDR_WIDTH'(4);
            missCountReg <= missCountReg + 32'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         delayedReg <= 1'b0;
      else
         delayedReg <= missReg ? 1'b0 : branchHazard;
   end

   assign bus.isDataHazard          = dataHazard;
   assign bus.isBranchHazard        = branchHazard;
   assign bus.isBranchHazardDelayed = delayedReg;
   assign bus.isMiss                = missReg;
   assign bus.redirectPc            = redirectReg;
   assign bus.missCount             = missCountReg;
   assign bus.watchdogTrip          = tripReg;
endmodule

// File: tb/tb_hazard_detector.sv
// Self-checking bench for hazard_detector: directed scenarios plus randomized branch transactions
// whose expected timelines come from a transaction-level reference model.
module tb_hazard_detector;
   localparam int RW    = 5;
   localparam int AW    = 32;
   localparam int LIMIT = 15;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   compared   = 0;
   int   mismatched = 0;

   logic [31:0] expMissCount = '0;
   logic [31:0] expRedirect  = '0;
   logic        expTrip      = 1'b0;

   hazard_detector_if #(.REG_ADDR_WIDTH(RW), .ADDR_WIDTH(AW)) bus ();

   hazard_detector #(.REG_ADDR_WIDTH(RW), .ADDR_WIDTH(AW), .WATCHDOG_LIMIT(LIMIT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic checkBit(input string tag, input logic observed, input logic expected);
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
      end
   endtask

   task automatic checkWord(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic clearInputs();
      bus.dValid = 1'b0;  bus.dIsBranch = 1'b0;
      bus.dRs1Used = 1'b0; bus.dRs2Used = 1'b0;
      bus.dRs1Addr = '0;  bus.dRs2Addr = '0;
      bus.eValid = 1'b0;  bus.eIsLoad = 1'b0; bus.eRdWrite = 1'b0; bus.eRdAddr = '0;
      bus.resolveValid = 1'b0; bus.resolveTaken = 1'b0; bus.resolvePredTaken = 1'b0;
      bus.resolveTarget = '0; bus.resolvePredTarget = '0; bus.resolvePc = '0;
   endtask

   task automatic applyStimulus(input bit valid, input bit taken, input bit predTaken,
                                input logic [31:0] target, input logic [31:0] predTarget,
                                input logic [31:0] pc);
      bus.resolveValid      = valid;
      bus.resolveTaken      = taken;
      bus.resolvePredTaken  = predTaken;
      bus.resolveTarget     = target;
      bus.resolvePredTarget = predTarget;
      bus.resolvePc         = pc;
   endtask

   // One whole branch transaction: optional load-use stall, decode entry, resolve after r cycles, and the aftermath.
   task automatic runBranch(input int stall, input int r, input bit taken, input bit predTaken,
                            input logic [31:0] target, input logic [31:0] predTarget,
                            input logic [31:0] pc);
      bit mis;
      if (taken != predTaken)
         mis = 1'b1;
      else if (taken)
         mis = (target != predTarget);
      else
         mis = 1'b0;

      for (int s = 0; s < stall; s++) begin
         bus.dValid = 1'b1; bus.dIsBranch = 1'b1; bus.dRs1Used = 1'b1; bus.dRs1Addr = 5'd7;
         bus.eValid = 1'b1; bus.eIsLoad = 1'b1; bus.eRdWrite = 1'b1; bus.eRdAddr = 5'd7;
         @(negedge clk);
         checkBit("stallDataHazard", bus.isDataHazard, 1'b1);
         checkBit("stallBranchHeld", bus.isBranchHazard, 1'b0);
         nextCycle();
      end

      bus.eValid = 1'b0; bus.eIsLoad = 1'b0; bus.eRdWrite = 1'b0;
      bus.dValid = 1'b1; bus.dIsBranch = 1'b1;
      @(negedge clk);
      checkBit("entryHazard", bus.isBranchHazard, 1'b1);
      checkBit("entryDelayed", bus.isBranchHazardDelayed, 1'b0);
      checkBit("entryTrip", bus.watchdogTrip, expTrip);
      nextCycle();

      bus.dValid = 1'b0; bus.dIsBranch = 1'b0; bus.dRs1Used = 1'b0;
      for (int c = 1; c <= r; c++) begin
         if (c == r) applyStimulus(1'b1, taken, predTaken, target, predTarget, pc);
         @(negedge clk);
         checkBit("pendingHazard", bus.isBranchHazard, 1'b1);
         checkBit("pendingDelayed", bus.isBranchHazardDelayed, 1'b1);
         checkBit("pendingMiss", bus.isMiss, 1'b0);
         checkBit("pendingTrip", bus.watchdogTrip, expTrip | ((c - 1) >= LIMIT));
         nextCycle();
      end

      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
      if ((r - 1) >= LIMIT) expTrip = 1'b1;
      if (mis) begin
         expMissCount = expMissCount + 32'd1;
         expRedirect  = taken ? target : pc + 32'd4;
      end
      @(negedge clk);
      checkBit("resolvedMiss", bus.isMiss, mis);
      checkWord("resolvedRedirect", bus.redirectPc, expRedirect);
      checkWord("resolvedCount", bus.missCount, expMissCount);
      checkBit("resolvedHazard", bus.isBranchHazard, 1'b0);
      checkBit("resolvedDelayed", bus.isBranchHazardDelayed, 1'b1);
      checkBit("resolvedTrip", bus.watchdogTrip, expTrip);
      nextCycle();

      @(negedge clk);
      checkBit("afterMiss", bus.isMiss, 1'b0);
      checkBit("afterDelayed", bus.isBranchHazardDelayed, 1'b0);
      checkWord("afterRedirect", bus.redirectPc, expRedirect);
      checkWord("afterCount", bus.missCount, expMissCount);
      nextCycle();
   endtask

   initial begin
      bit          dv, br, u1, u2, ev, ld, wr, expHaz, tk, pt;
      logic [4:0]  a1, a2, rd;
      logic [31:0] rnd, tgt, ptgt, pcVal;

      clearInputs();
      rst = 1'b1;
      bus.dValid = 1'b1; bus.dIsBranch = 1'b1;
      @(negedge clk);
      checkBit("resetMiss", bus.isMiss, 1'b0);
      checkWord("resetRedirect", bus.redirectPc, 32'h0);
      checkWord("resetCount", bus.missCount, 32'h0);
      checkBit("resetTrip", bus.watchdogTrip, 1'b0);
      checkBit("resetDelayed", bus.isBranchHazardDelayed, 1'b0);
      checkBit("resetCombBranch", bus.isBranchHazard, 1'b1);
      bus.dValid = 1'b0; bus.dIsBranch = 1'b0;
      nextCycle();
      rst = 1'b0;
      nextCycle();

      // Directed load-use: x5 hazards, register 0 never does.
      bus.eValid = 1'b1; bus.eIsLoad = 1'b1; bus.eRdWrite = 1'b1; bus.eRdAddr = 5'd5;
      bus.dValid = 1'b1; bus.dRs2Used = 1'b1; bus.dRs2Addr = 5'd5;
      #1 checkBit("loadUseX5", bus.isDataHazard, 1'b1);
      bus.eRdAddr = 5'd0; bus.dRs2Addr = 5'd0;
      #1 checkBit("loadUseX0", bus.isDataHazard, 1'b0);
      clearInputs();
      nextCycle();

      // Randomized combinational checks of the load-use rule and its priority over branch entry.
      for (int i = 0; i < 40; i++) begin
         dv = ($urandom_range(0, 3) != 0); br = ($urandom_range(0, 1) == 1);
         u1 = ($urandom_range(0, 1) == 1); u2 = ($urandom_range(0, 1) == 1);
         ev = ($urandom_range(0, 3) != 0); ld = ($urandom_range(0, 3) != 0);
         wr = ($urandom_range(0, 3) != 0);
         a1 = 5'($urandom_range(0, 3)); a2 = 5'($urandom_range(0, 3)); rd = 5'($urandom_range(0, 3));
         bus.dValid = dv; bus.dIsBranch = br; bus.dRs1Used = u1; bus.dRs2Used = u2;
         bus.dRs1Addr = a1; bus.dRs2Addr = a2;
         bus.eValid = ev; bus.eIsLoad = ld; bus.eRdWrite = wr; bus.eRdAddr = rd;
         expHaz = 1'b0;
         if (dv && ev && ld && wr && rd != 5'd0)
            expHaz = (u1 && a1 == rd) || (u2 && a2 == rd);
         @(negedge clk);
         checkBit("randDataHazard", bus.isDataHazard, expHaz);
         checkBit("randBranchEntry", bus.isBranchHazard, dv && br && !expHaz);
         bus.dValid = 1'b0;
         nextCycle();
      end
      clearInputs();
      nextCycle();
      nextCycle();

      runBranch(0, 3, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0000_0040);
      runBranch(0, 2, 1'b1, 1'b0, 32'h0000_0200, 32'h0000_0000, 32'h0000_0100);
      runBranch(0, 1, 1'b0, 1'b1, 32'h0000_0080, 32'h0000_0080, 32'hFFFF_FFFC);
      runBranch(2, 2, 1'b1, 1'b1, 32'h0000_0300, 32'h0000_0310, 32'h0000_0020);
      runBranch(0, 20, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0000_0500);
      runBranch(0, 2, 1'b1, 1'b1, 32'h0000_0600, 32'h0000_0600, 32'h0000_0580);

      // Reset while PENDING with a mispredict resolving in the same cycle.
      bus.dValid = 1'b1; bus.dIsBranch = 1'b1;
      nextCycle();
      bus.dValid = 1'b0; bus.dIsBranch = 1'b0;
      @(negedge clk);
      checkBit("preResetPending", bus.isBranchHazard, 1'b1);
      nextCycle();
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0000_0900, 32'h0, 32'h0000_0800);
      rst = 1'b1;
      #1;
      checkBit("midResetHazard", bus.isBranchHazard, 1'b0);
      checkBit("midResetDelayed", bus.isBranchHazardDelayed, 1'b0);
      checkBit("midResetMiss", bus.isMiss, 1'b0);
      checkWord("midResetCount", bus.missCount, 32'h0);
      checkWord("midResetRedirect", bus.redirectPc, 32'h0);
      checkBit("midResetTrip", bus.watchdogTrip, 1'b0);
      nextCycle();
      rst = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
      expMissCount = '0; expRedirect = '0; expTrip = 1'b0;
      @(negedge clk);
      checkBit("postResetMiss", bus.isMiss, 1'b0);
      checkWord("postResetCount", bus.missCount, 32'h0);
      nextCycle();
      @(negedge clk);
      checkBit("postResetMiss2", bus.isMiss, 1'b0);
      checkBit("postResetHazard", bus.isBranchHazard, 1'b0);
      nextCycle();

      // Mispredict resolving in IDLE: pulse still fires and masks a branch entering that cycle.
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0000_0440, 32'h0000_0440, 32'h0000_0400);
      @(negedge clk);
      checkBit("idleResolveHazard", bus.isBranchHazard, 1'b0);
      nextCycle();
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
      bus.dValid = 1'b1; bus.dIsBranch = 1'b1;
      expMissCount = expMissCount + 32'd1; expRedirect = 32'h0000_0440;
      @(negedge clk);
      checkBit("idleMiss", bus.isMiss, 1'b1);
      checkWord("idleRedirect", bus.redirectPc, expRedirect);
      checkWord("idleCount", bus.missCount, expMissCount);
      checkBit("idleMissMask", bus.isBranchHazard, 1'b0);
      nextCycle();
      @(negedge clk);
      checkBit("entryAfterMiss", bus.isBranchHazard, 1'b1);
      checkBit("delayedAfterMiss", bus.isBranchHazardDelayed, 1'b0);
      nextCycle();
      bus.dValid = 1'b0; bus.dIsBranch = 1'b0;
      @(negedge clk);
      checkBit("pendingAfterMiss", bus.isBranchHazardDelayed, 1'b1);
      nextCycle();
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0000_0444);
      nextCycle();
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
      @(negedge clk);
      checkBit("correctNoMiss", bus.isMiss, 1'b0);
      checkBit("correctIdle", bus.isBranchHazard, 1'b0);
      nextCycle();
      nextCycle();

      // Randomized branch transactions against the timeline model.
      for (int i = 0; i < 40; i++) begin
         tk   = ($urandom_range(0, 1) == 1);
         pt   = ($urandom_range(0, 1) == 1);
         tgt  = ($urandom_range(0, 1) == 1) ? 32'h0000_0200 : 32'h0000_0300;
         ptgt = ($urandom_range(0, 1) == 1) ? 32'h0000_0200 : 32'h0000_0300;
         rnd  = $urandom;
         pcVal = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC : {rnd[31:2], 2'b00};
         runBranch($urandom_range(0, 2), $urandom_range(1, 18), tk, pt, tgt, ptgt, pcVal);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
